result_display_stage: RTL and testbench

//  Downstream stage of the 4-bit adder/subtractor: latches Sum/Add_Cout/Overflow/Add_Sub on a capture strobe,

---
 rtl/result_display_stage_pkg.sv | 64 ++++++
 rtl/result_display_stage_seg7_decode.sv | 29 ++
 rtl/result_display_stage.sv | 136 +++++++++++++
 tb/tb_result_display_stage.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/result_display_stage_pkg.sv
// Shared glyph codes, active-low segment constants and the result-to-glyph
// conversion used by the result display stage.
package result_display_stage_pkg;

    typedef logic [3:0] glyph_t;

    localparam glyph_t GLYPH_BLANK = 4'd10;
    localparam glyph_t GLYPH_MINUS = 4'd11;
    localparam glyph_t GLYPH_E     = 4'd12;

    // Segment order {g,f,e,d,c,b,a}; a 0 lights the segment.
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;
    localparam logic [6:0] SEG_E     = 7'h06;

    typedef struct packed {
        glyph_t d3;
        glyph_t d2;
        glyph_t d1;
        glyph_t d0;
    } frame_t;

    function automatic frame_t build_frame(input logic [3:0] sum, input logic cout,
                                           input logic ovf, input logic sub);
        frame_t     f;
        logic [4:0] v;
        logic [3:0] mag;
        f.d3 = GLYPH_BLANK;
        f.d2 = GLYPH_BLANK;
        f.d1 = GLYPH_BLANK;
        f.d0 = GLYPH_BLANK;
        v    = {cout, sum};
        mag  = sum[3] ? (~sum + 4'd1) : sum;
        if (sub) begin
            // Negating 4'b1000 wraps back to 4'b1000, which reads as magnitude 8.
            f.d0 = mag;
            f.d1 = sum[3] ? GLYPH_MINUS : GLYPH_BLANK;
            f.d3 = ovf ? GLYPH_E : GLYPH_BLANK;
        end else if (v >= 5'd30) begin
            f.d1 = 4'd3;
            f.d0 = 4'(v - 5'd30);
        end else if (v >= 5'd20) begin
            f.d1 = 4'd2;
            f.d0 = 4'(v - 5'd20);
        end else if (v >= 5'd10) begin
            f.d1 = 4'd1;
            f.d0 = 4'(v - 5'd10);
        end else begin
            f.d0 = v[3:0];
        end
        return f;
    endfunction

endpackage

// File: rtl/result_display_stage_seg7_decode.sv
// Combinational glyph code to active-low 7-segment pattern; unknown codes
// render as blank.
module seg7_decode
    import result_display_stage_pkg::*;
(
    input  logic [3:0] glyph,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (glyph)
            4'd0:        seg = SEG_0;
            4'd1:        seg = SEG_1;
            4'd2:        seg = SEG_2;
            4'd3:        seg = SEG_3;
            4'd4:        seg = SEG_4;
            4'd5:        seg = SEG_5;
            4'd6:        seg = SEG_6;
            4'd7:        seg = SEG_7;
            4'd8:        seg = SEG_8;
            4'd9:        seg = SEG_9;
            GLYPH_MINUS: seg = SEG_MINUS;
            GLYPH_E:     seg = SEG_E;
            default:     seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/result_display_stage.sv
// Latches adder/subtractor results, converts them to decimal glyphs and scans
// a 4-digit common-anode display. Define OVF_BLINK_EN to blink on overflow.
module result_display_stage
    import result_display_stage_pkg::*;
#(
    parameter int SCAN_DIV = 100_000
`ifdef OVF_BLINK_EN
    , parameter int BLINK_DIV = 25_000_000
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] Sum,
    input  logic       Add_Cout,
    input  logic       Overflow,
    input  logic       Add_Sub,
    input  logic       capture,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       disp_valid
);

    localparam int SCAN_W = $clog2(SCAN_DIV);

    logic [3:0]        cap_sum;
    logic              cap_cout;
    logic              cap_ovf;
    logic              cap_sub;
    frame_t            glyphs;
    logic              ovf_shown;
    logic              active;
    logic [SCAN_W-1:0] scan_cnt;
    logic [1:0]        scan_idx;
    logic              blink_off;
    glyph_t            cur_glyph;
    logic [6:0]        cur_seg;

    always_ff @(posedge clk) begin
        if (rst) begin
            cap_sum    <= 4'd0;
            cap_cout   <= 1'b0;
            cap_ovf    <= 1'b0;
            cap_sub    <= 1'b0;
            disp_valid <= 1'b0;
        end else if (capture) begin
            cap_sum    <= Sum;
            cap_cout   <= Add_Cout;
            cap_ovf    <= Overflow;
            cap_sub    <= Add_Sub;
            disp_valid <= 1'b1;
        end
    end

    // Whole frame is re-registered together so the scan never mixes digits
    // from two different results.
    always_ff @(posedge clk) begin
        if (rst) begin
            glyphs    <= build_frame(4'd0, 1'b0, 1'b0, 1'b0);
            ovf_shown <= 1'b0;
        end else begin
            glyphs    <= build_frame(cap_sum, cap_cout, cap_ovf, cap_sub);
            ovf_shown <= cap_ovf & cap_sub;
        end
    end

    // The scan holds still on the release edge so digit 0 gets a full slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            active   <= 1'b0;
            scan_cnt <= '0;
            scan_idx <= 2'd0;
        end else begin
            active <= 1'b1;
            if (active) begin
                if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
                    scan_cnt <= '0;
                    scan_idx <= scan_idx + 2'd1;
                end else begin
                    scan_cnt <= scan_cnt + 1'b1;
                end
            end
        end
    end

`ifdef OVF_BLINK_EN
    localparam int BLINK_W = $clog2(BLINK_DIV);

    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_phase;

    always_ff @(posedge clk) begin
        if (rst || capture) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    assign blink_off = blink_phase & ovf_shown;
`else
    assign blink_off = 1'b0;
`endif

    always_comb begin
        cur_glyph = glyphs.d0;
        case (scan_idx)
            2'd0: cur_glyph = glyphs.d0;
            2'd1: cur_glyph = glyphs.d1;
            2'd2: cur_glyph = glyphs.d2;
            2'd3: cur_glyph = glyphs.d3;
            default: cur_glyph = glyphs.d0;
        endcase
    end

    seg7_decode u_decode (
        .glyph(cur_glyph),
        .seg  (cur_seg)
    );

    // Blank glyphs still drive their anode so every digit gets equal on-time.
    always_comb begin
        seg = SEG_BLANK;
        an  = 4'hF;
        if (active) begin
            seg = cur_seg;
            if (!blink_off) begin
                an = ~(4'b0001 << scan_idx);
            end
        end
    end

endmodule

// File: tb/tb_result_display_stage.sv
// Self-checking bench for result_display_stage: a cycle-level behavioural
// model compared every cycle, plus directed literal checks.
module tb_result_display_stage;

    localparam int SCAN_DIV = 4;
`ifdef OVF_BLINK_EN
    localparam int BLINK_DIV = 8;
`endif
    localparam int G_BLANK = -1;
    localparam int G_MINUS = 10;
    localparam int G_E     = 11;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       capture = 1'b0;
    logic [3:0] Sum = 4'd0;
    logic       Add_Cout = 1'b0;
    logic       Overflow = 1'b0;
    logic       Add_Sub = 1'b0;
    logic [6:0] seg;
    logic [3:0] an;
    logic       disp_valid;

    int vectors = 0;
    int miscompares = 0;

    result_display_stage #(
        .SCAN_DIV(SCAN_DIV)
`ifdef OVF_BLINK_EN
        , .BLINK_DIV(BLINK_DIV)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .Sum       (Sum),
        .Add_Cout  (Add_Cout),
        .Overflow  (Overflow),
        .Add_Sub   (Add_Sub),
        .capture   (capture),
        .seg       (seg),
        .an        (an),
        .disp_valid(disp_valid)
    );

    always #5 clk = ~clk;

    // Model state: what was captured, what is on display, and elapsed time.
    bit m_ready = 0;
    bit m_active = 0;
    bit m_valid = 0;
    int m_ticks = 0;
    int m_since_cap = 0;
    int cap_sum = 0, cap_cout = 0, cap_ovf = 0, cap_sub = 0;
    int shown_sum = 0, shown_cout = 0, shown_ovf = 0, shown_sub = 0;

    function automatic int glyph_at(input int sum, input int cout, input int ovf,
                                    input int sub, input int pos);
        int v;
        int s;
        if (sub != 0) begin
            s = (sum >= 8) ? sum - 16 : sum;
            if (pos == 0) return (s < 0) ? -s : s;
            if (pos == 1) return (s < 0) ? G_MINUS : G_BLANK;
            if (pos == 3) return (ovf != 0) ? G_E : G_BLANK;
            return G_BLANK;
        end
        v = cout * 16 + sum;
        if (pos == 0) return v % 10;
        if (pos == 1 && v >= 10) return v / 10;
        return G_BLANK;
    endfunction

    function automatic logic [6:0] seg_of(input int g);
        case (g)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            G_MINUS: return 7'h3F;
            G_E: return 7'h06;
            default: return 7'h7F;
        endcase
    endfunction

    always @(posedge clk) begin
        m_ready <= 1'b1;
        if (rst) begin
            m_active    <= 1'b0;
            m_valid     <= 1'b0;
            m_ticks     <= 0;
            m_since_cap <= 0;
            cap_sum <= 0; cap_cout <= 0; cap_ovf <= 0; cap_sub <= 0;
            shown_sum <= 0; shown_cout <= 0; shown_ovf <= 0; shown_sub <= 0;
        end else begin
            m_active <= 1'b1;
            if (m_active) m_ticks <= m_ticks + 1;
            shown_sum <= cap_sum; shown_cout <= cap_cout;
            shown_ovf <= cap_ovf; shown_sub <= cap_sub;
            if (capture) begin
                cap_sum  <= int'(Sum);
                cap_cout <= int'(Add_Cout);
                cap_ovf  <= int'(Overflow);
                cap_sub  <= int'(Add_Sub);
                m_valid  <= 1'b1;
                m_since_cap <= 0;
            end else begin
                m_since_cap <= m_since_cap + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_ready) begin : compare
            logic [6:0] es;
            logic [3:0] ea;
            int idx;
            es = 7'h7F;
            ea = 4'hF;
            if (m_active) begin
                idx = (m_ticks / SCAN_DIV) % 4;
                es  = seg_of(glyph_at(shown_sum, shown_cout, shown_ovf, shown_sub, idx));
                ea  = ~(4'b0001 << idx);
`ifdef OVF_BLINK_EN
                if (shown_ovf != 0 && shown_sub != 0 && ((m_since_cap / BLINK_DIV) % 2) == 1)
                    ea = 4'hF;
`endif
            end
            vectors++;
            if (seg !== es || an !== ea || disp_valid !== m_valid) begin
                miscompares++;
                $display("[TB] FAIL model_cycle t=%0t: seg=%h an=%b valid=%b, expected seg=%h an=%b valid=%b",
                         $time, seg, an, disp_valid, es, ea, m_valid);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic checkOutput(input string name, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", name, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic sub, input logic [3:0] s, input logic co, input logic ov);
        Add_Sub  = sub;
        Sum      = s;
        Add_Cout = co;
        Overflow = ov;
        capture  = 1'b1;
        tick(1);
        capture  = 1'b0;
        tick(1);
    endtask

    task automatic checkDigit(input string name, input int idx, input logic [6:0] exp);
        logic [3:0] want;
        bit hit;
        want = ~(4'b0001 << idx);
        hit  = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge clk);
            if (an == want) begin
                hit = 1;
                checkOutput(name, {1'b0, seg}, {1'b0, exp});
            end
        end
        if (!hit) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL %s_timeout: an=%b never reached, expected %b", name, an, want);
        end
    endtask

    logic [3:0] prev_an;
    logic [3:0] want_an;
    bit         found;
    int         off_cnt;
    int         exp_off;

    initial begin
        tick(2);
        @(negedge clk);
        checkOutput("reset_seg", {1'b0, seg}, 8'h7F);
        checkOutput("reset_an", {4'b0, an}, 8'h0F);
        checkOutput("reset_valid", {7'b0, disp_valid}, 8'h00);
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("release_an", {4'b0, an}, 8'h0E);
        checkOutput("release_seg", {1'b0, seg}, 8'h40);

        applyStimulus(1'b0, 4'hF, 1'b1, 1'b0);
        checkDigit("add31_tens", 1, 7'h30);
        checkDigit("add31_units", 0, 7'h79);
        checkOutput("add31_valid", {7'b0, disp_valid}, 8'h01);
        checkDigit("add31_d3", 3, 7'h7F);

        applyStimulus(1'b0, 4'd9, 1'b0, 1'b0);
        checkDigit("add9_tens_blank", 1, 7'h7F);
        checkDigit("add9_units", 0, 7'h10);

        applyStimulus(1'b0, 4'd4, 1'b1, 1'b1);
        checkDigit("add20_tens", 1, 7'h24);
        checkDigit("add20_units", 0, 7'h40);
        checkDigit("add20_no_e", 3, 7'h7F);

        applyStimulus(1'b1, 4'd5, 1'b0, 1'b0);
        checkDigit("subp5_sign", 1, 7'h7F);
        checkDigit("subp5_units", 0, 7'h12);

        applyStimulus(1'b1, 4'b1101, 1'b0, 1'b0);
        checkDigit("subm3_sign", 1, 7'h3F);
        checkDigit("subm3_units", 0, 7'h30);
        checkDigit("subm3_d3", 3, 7'h7F);

        found   = 0;
        prev_an = an;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (an == 4'b1110 && prev_an == 4'b0111) found = 1;
            else prev_an = an;
        end
        if (!found) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL scan_sync: no 0111->1110 transition seen, an=%b", an);
        end else begin
            for (int j = 1; j < 20; j++) begin
                @(negedge clk);
                want_an = ~(4'b0001 << ((j / 4) % 4));
                checkOutput("scan_an", {4'b0, an}, {4'b0, want_an});
            end
        end

        applyStimulus(1'b1, 4'b1000, 1'b0, 1'b1);
        off_cnt = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (an == 4'hF) off_cnt++;
        end
`ifdef OVF_BLINK_EN
        exp_off = 16;
`else
        exp_off = 0;
`endif
        checkOutput("ovf_dark_cycles", 8'(off_cnt), 8'(exp_off));
        checkDigit("subm8_e", 3, 7'h06);
        checkDigit("subm8_sign", 1, 7'h3F);
        checkDigit("subm8_units", 0, 7'h00);

        @(posedge clk); #2;
        rst      = 1'b1;
        capture  = 1'b1;
        Add_Sub  = 1'b0;
        Sum      = 4'd5;
        Add_Cout = 1'b0;
        Overflow = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midreset_seg", {1'b0, seg}, 8'h7F);
        checkOutput("midreset_an", {4'b0, an}, 8'h0F);
        checkOutput("midreset_valid", {7'b0, disp_valid}, 8'h00);
        @(posedge clk); #2;
        rst     = 1'b0;
        capture = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midreset_release_an", {4'b0, an}, 8'h0E);
        checkOutput("midreset_release_seg", {1'b0, seg}, 8'h40);
        checkOutput("midreset_release_valid", {7'b0, disp_valid}, 8'h00);
        tick(12);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
